// File: rtl/fd_pkg.sv
// fd_pkg: shared declarations for the fetch->decode stage buffer.
//   fd_state_t  occupancy state of the two-entry buffer (EMPTY, ONE, FULL)
//   FD_NOP_INS  bubble instruction shown to decode when nothing is valid
//   FD_CNT_W    width of the optional performance counters
package fd_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fd_state_t;

    localparam logic [31:0] FD_NOP_INS = 32'hdc000000;
    localparam int          FD_CNT_W   = 32;

endpackage

// File: rtl/fd_perf_cnt.sv
// fd_perf_cnt: free-running event counters for the fetch->decode buffer.
// Ports:
//   clk        clock, rising edge
//   rstd       asynchronous active-low reset, clears both counters
//   stall_evt  decode is holding a valid entry without consuming it
//   flush_evt  a flush discarded at least one valid entry
//   stall_cnt  number of stall cycles, wraps modulo 2^32
//   flush_cnt  number of effective flushes, wraps modulo 2^32
module fd_perf_cnt
    import fd_pkg::*;
(
    input  logic                clk,
    input  logic                rstd,
    input  logic                stall_evt,
    input  logic                flush_evt,
    output logic [FD_CNT_W-1:0] stall_cnt,
    output logic [FD_CNT_W-1:0] flush_cnt
);

    logic [1:0]          evt;
    logic [FD_CNT_W-1:0] cnt_reg [2];

    assign evt = {flush_evt, stall_evt};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rstd) begin
                if (!rstd) begin
                    cnt_reg[gi] <= '0;
                end else if (evt[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];

endmodule

// File: rtl/fd_stage_buf.sv
// fd_stage_buf: fetch->decode stage register with valid/ready handshake
// and a two-entry skid buffer (main + skid). Outputs come from main only.
// Build option: define FD_PERF_CNT_EN to add stall_cnt/flush_cnt ports.
// Ports:
//   clk, rstd            clock (rising) and asynchronous active-low reset
//   flush                discard all held entries (redirect)
//   in_valid/in_ready    fetch handshake; in_ready is registered
//   pc_in, ins_in        fetched PC and instruction
//   out_valid/out_ready  decode handshake
//   pc_out, ins_out      head entry; ins_out is NOP_INS when out_valid=0
//   stall_cnt, flush_cnt (FD_PERF_CNT_EN only) performance counters
module fd_stage_buf
    import fd_pkg::*;
#(
    parameter int               PC_W    = 32,
    parameter int               INS_W   = 32,
    parameter logic [INS_W-1:0] NOP_INS = FD_NOP_INS
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [INS_W-1:0] ins_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  pc_out,
    output logic [INS_W-1:0] ins_out
`ifdef FD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    fd_state_t        state_reg, state_next;
    logic             in_ready_reg;
    logic [PC_W-1:0]  main_pc_reg, skid_pc_reg;
    logic [INS_W-1:0] main_ins_reg, skid_ins_reg;

    logic accept, pop;
    logic load_main_in, load_main_skid, load_skid_in;

    assign out_valid = (state_reg != EMPTY);
    assign in_ready  = in_ready_reg;
    assign accept    = in_valid & in_ready_reg;
    assign pop       = out_valid & out_ready;

    // Next state and data-register load enables. Flush wins over
    // everything: nothing is loaded, so an entry accepted in the same
    // cycle is dropped and pc_out keeps its last value.
    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_next   = FULL;
                        load_skid_in = 1'b1;
                    end else if (pop) begin
                        state_next   = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_next     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b1;
            main_pc_reg  <= '0;
            main_ins_reg <= NOP_INS;
            skid_pc_reg  <= '0;
            skid_ins_reg <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != FULL);
            if (load_main_in) begin
                main_pc_reg  <= pc_in;
                main_ins_reg <= ins_in;
            end else if (load_main_skid) begin
                main_pc_reg  <= skid_pc_reg;
                main_ins_reg <= skid_ins_reg;
            end
            if (load_skid_in) begin
                skid_pc_reg  <= pc_in;
                skid_ins_reg <= ins_in;
            end
        end
    end

    assign pc_out  = main_pc_reg;
    assign ins_out = out_valid ? main_ins_reg : NOP_INS;

`ifdef FD_PERF_CNT_EN
    fd_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rstd      (rstd),
        .stall_evt (out_valid & ~out_ready),
        .flush_evt (flush & out_valid),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`endif

endmodule
